// File: rtl/monolith_pkg.sv
// Shared types and defaults for the monolith hash core arbitration slice.
package monolith_pkg;

   localparam int unsigned WORD_WIDTH_DEFAULT = 31;
   localparam int unsigned STATE_SIZE_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   typedef logic [WORD_WIDTH_DEFAULT-1:0] state_t [STATE_SIZE_DEFAULT];

endpackage

// File: rtl/monolith_hash_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, with wrap.
module rr_arbiter #(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   // Scan (last_grant+1) mod N_REQ upward and take the first active request.
   always_comb begin
      int unsigned      idx;
      logic [IDX_W-1:0] idx_w;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      idx         = 0;
      idx_w       = '0;
      for (int unsigned off = 1; off <= N_REQ; off++) begin
         idx   = (32'(last_grant) + off) % N_REQ;
         idx_w = IDX_W'(idx);
         if (!grant_valid && req[idx_w]) begin
            grant[idx_w] = 1'b1;
            grant_idx    = idx_w;
            grant_valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/monolith_hash_arbiter.sv
// Shares one monolith permutation core between N_REQ requesters, one job at a time.
module monolith_hash_arbiter
   import monolith_pkg::*;
#(
   parameter  int unsigned N_REQ          = 4,
   parameter  int unsigned WORD_WIDTH     = WORD_WIDTH_DEFAULT,
   parameter  int unsigned STATE_SIZE     = STATE_SIZE_DEFAULT,
   parameter  int unsigned TIMEOUT_CYCLES = 64,
   localparam int unsigned ID_W           = $clog2(N_REQ),
   localparam int unsigned WD_W           = $clog2(TIMEOUT_CYCLES) + 1
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic [N_REQ-1:0]                                 req_valid,
   output logic [N_REQ-1:0]                                 req_ready,
   input  logic [N_REQ-1:0][STATE_SIZE-1:0][WORD_WIDTH-1:0] req_state,
   output logic                                             resp_valid,
   input  logic                                             resp_ready,
   output logic [ID_W-1:0]                                  resp_id,
   output logic                                             resp_error,
   output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]            resp_state,
   output logic                                             core_reset,
   output logic                                             core_in_valid,
   output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]            core_state_in,
   input  logic                                             core_out_valid,
   input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]            core_state_out,
   output logic                                             busy,
   output logic [15:0]                                      jobs_done
);

   arb_state_e                           state;
   logic [ID_W-1:0]                      last_grant;
   logic [ID_W-1:0]                      job_id;
   logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] job_state;
   logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] resp_state_q;
   logic [ID_W-1:0]                      resp_id_q;
   logic                                 resp_error_q;
   logic                                 resp_valid_q;
   logic [WD_W-1:0]                      watchdog;
   logic [15:0]                          jobs_done_q;
   logic                                 core_reset_q;
   logic                                 core_in_valid_q;

   logic [N_REQ-1:0]                     grant;
   logic [ID_W-1:0]                      grant_idx;
   logic                                 grant_valid;
   logic                                 wd_expired;

   rr_arbiter #(
      .N_REQ(N_REQ)
   ) u_rr_arbiter (
      .req         (req_valid),
      .last_grant  (last_grant),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   assign wd_expired = (watchdog == WD_W'(TIMEOUT_CYCLES - 1));

   // Accept is offered only in IDLE; a cycle with reset asserted never accepts.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && !reset)
         req_ready = grant;
   end

   // The core is held in reset combinationally during our own reset cycle too.
   assign core_reset    = core_reset_q | reset;
   assign core_in_valid = core_in_valid_q;
   assign core_state_in = job_state;
   assign resp_valid    = resp_valid_q;
   assign resp_id       = resp_id_q;
   assign resp_error    = resp_error_q;
   assign resp_state    = resp_state_q;
   assign busy          = (state != IDLE);
   assign jobs_done     = jobs_done_q;

   // Job sequencer: grant in IDLE, run core with watchdog, hold result until taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         last_grant      <= ID_W'(N_REQ - 1);
         job_id          <= '0;
         job_state       <= '0;
         resp_state_q    <= '0;
         resp_id_q       <= '0;
         resp_error_q    <= 1'b0;
         resp_valid_q    <= 1'b0;
         watchdog        <= '0;
         jobs_done_q     <= '0;
         core_reset_q    <= 1'b1;
         core_in_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  job_state       <= req_state[grant_idx];
                  job_id          <= grant_idx;
                  last_grant      <= grant_idx;
                  watchdog        <= '0;
                  core_reset_q    <= 1'b0;
                  core_in_valid_q <= 1'b1;
                  state           <= RUN;
               end
            end
            RUN: begin
               watchdog <= watchdog + 1'b1;
               // A valid result in the timeout cycle takes priority over the abort.
               if (core_out_valid) begin
                  resp_state_q    <= core_state_out;
                  resp_error_q    <= 1'b0;
                  resp_id_q       <= job_id;
                  resp_valid_q    <= 1'b1;
                  jobs_done_q     <= jobs_done_q + 16'd1;
                  core_reset_q    <= 1'b1;
                  core_in_valid_q <= 1'b0;
                  state           <= RESP;
               end else if (wd_expired) begin
                  resp_state_q    <= '0;
                  resp_error_q    <= 1'b1;
                  resp_id_q       <= job_id;
                  resp_valid_q    <= 1'b1;
                  core_reset_q    <= 1'b1;
                  core_in_valid_q <= 1'b0;
                  state           <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_monolith_hash_arbiter.sv
// Scoreboard bench for monolith_hash_arbiter with a behavioural core model.
module tb_monolith_hash_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 31;
   localparam int unsigned S  = 16;
   localparam int unsigned TO = 64;

   typedef logic [S-1:0][W-1:0] st_t;
   typedef struct {
      logic [1:0] id;
      logic       err;
      st_t        st;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [N-1:0]           req_valid;
   logic [N-1:0]           req_ready;
   logic [N-1:0][S-1:0][W-1:0] req_state;
   logic                   resp_valid;
   logic                   resp_ready;
   logic [1:0]             resp_id;
   logic                   resp_error;
   st_t                    resp_state;
   logic                   core_reset;
   logic                   core_in_valid;
   st_t                    core_state_in;
   logic                   core_out_valid;
   st_t                    core_state_out;
   logic                   busy;
   logic [15:0]            jobs_done;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   mcnt  = 0;
   logic core_hang = 1'b0;
   exp_t sb[$];

   monolith_hash_arbiter #(
      .N_REQ(N), .WORD_WIDTH(W), .STATE_SIZE(S), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_state(req_state), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_error(resp_error), .resp_state(resp_state),
      .core_reset(core_reset), .core_in_valid(core_in_valid),
      .core_state_in(core_state_in), .core_out_valid(core_out_valid),
      .core_state_out(core_state_out), .busy(busy), .jobs_done(jobs_done)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency measurements.
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in permutation: each word is 3x+i+0x1234 mod 2^31.
   function automatic st_t core_fn(input st_t x);
      st_t r;
      for (int i = 0; i < S; i++) r[i] = W'(x[i] * 3 + i + 32'h1234);
      return r;
   endfunction

   // Core model: out_valid in the 8th cycle of in_valid unless hung.
   always @(posedge clk) begin
      if (core_reset) mcnt <= 0;
      else if (core_in_valid && mcnt < 7) mcnt <= mcnt + 1;
   end
   assign core_out_valid = core_in_valid && !core_reset && !core_hang && (mcnt == 7);
   assign core_state_out = core_fn(core_state_in);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: pop the scoreboard on each response handshake; check every accept is one-hot in IDLE.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && resp_valid && resp_ready) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL resp_unexpected: got response id=%0d, required no response", resp_id);
         end else begin
            e = sb.pop_front();
            if (resp_id !== e.id || resp_error !== e.err || resp_state !== e.st) begin
               fails++;
               $display("FAIL resp_check: got id=%0d err=%0b state=%h, required id=%0d err=%0b state=%h",
                        resp_id, resp_error, resp_state, e.id, e.err, e.st);
            end
         end
      end
      if (req_ready !== '0) begin
         tests++;
         if (!$onehot(req_ready) || busy !== 1'b0) begin
            fails++;
            $display("FAIL req_ready_onehot: got req_ready=%b busy=%b, required one-hot with busy=0",
                     req_ready, busy);
         end
      end
   end

   task automatic push_exp(input int id, input logic err);
      exp_t e;
      e.id  = 2'(id);
      e.err = err;
      e.st  = err ? st_t'(0) : core_fn(req_state[id]);
      sb.push_back(e);
   endtask

   task automatic wait_accept(input string name, input int max, output int c);
      c = -1;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (req_ready !== '0) begin
            c = cyc;
            return;
         end
      end
      tests++; fails++;
      $display("FAIL %s: got no accept within %0d cycles, required an accept", name, max);
   endtask

   task automatic wait_resp(input string name, input int max, output int c);
      c = -1;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            c = cyc;
            return;
         end
      end
      tests++; fails++;
      $display("FAIL %s: got no resp_valid within %0d cycles, required a response", name, max);
   endtask

   task automatic wait_sb_empty(input string name, input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (sb.size() == 0) return;
      end
      tests++; fails++;
      $display("FAIL %s: got %0d outstanding responses, required 0", name, sb.size());
      sb.delete();
   endtask

   task automatic run_job(input string name, input logic [N-1:0] mask, input int id,
                          input logic err, output int acc, output int rsp);
      push_exp(id, err);
      @(posedge clk); #1 req_valid = mask;
      wait_accept(name, 40, acc);
      check({name, "_grant"}, 64'(req_ready), 64'(1) << id);
      @(posedge clk); #1 req_valid = '0;
      wait_resp(name, 200, rsp);
      wait_sb_empty(name, 40);
   endtask

   initial begin
      int   acc, rsp, prev_acc;
      st_t  exp_st;

      reset      = 1'b1;
      req_valid  = '0;
      resp_ready = 1'b1;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < S; j++)
            req_state[i][j] = W'(i * 16 + j);

      // Reset state, with requests present to confirm no accept during reset.
      repeat (3) @(posedge clk);
      #1 req_valid = 4'hF;
      @(negedge clk);
      check("rst_busy", 64'(busy), 0);
      check("rst_resp_valid", 64'(resp_valid), 0);
      check("rst_core_reset", 64'(core_reset), 1);
      check("rst_core_in_valid", 64'(core_in_valid), 0);
      check("rst_jobs_done", 64'(jobs_done), 0);
      check("rst_resp_id_err", {resp_id, resp_error}, 0);
      check("rst_resp_state_zero", 64'(resp_state === '0), 1);
      check("rst_req_ready", 64'(req_ready), 0);
      @(posedge clk); #1 req_valid = '0; reset = 1'b0;

      // Single requester with latency from accept to resp_valid.
      run_job("single", 4'b0001, 0, 1'b0, acc, rsp);
      check("single_latency", 64'(rsp - acc), 9);
      @(negedge clk);
      check("single_jobs_done", 64'(jobs_done), 1);

      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;

      // Fairness: all four requesting continuously for 8 jobs.
      for (int k = 0; k < 8; k++) push_exp(k % 4, 1'b0);
      @(posedge clk); #1 req_valid = 4'hF;
      prev_acc = 0;
      for (int k = 0; k < 8; k++) begin
         wait_accept("fair", 40, acc);
         check("fair_grant", 64'(req_ready), 64'(1) << (k % 4));
         if (k > 0) check("fair_spacing", 64'(acc - prev_acc), 10);
         prev_acc = acc;
      end
      @(posedge clk); #1 req_valid = '0;
      wait_sb_empty("fair_drain", 60);
      check("fair_jobs_done", 64'(jobs_done), 8);

      // Backpressure: response held for 20 cycles while others request.
      resp_ready = 1'b0;
      push_exp(2, 1'b0);
      exp_st = core_fn(req_state[2]);
      @(posedge clk); #1 req_valid = 4'b0100;
      wait_accept("bp", 40, acc);
      @(posedge clk); #1 req_valid = '0;
      wait_resp("bp", 40, rsp);
      @(posedge clk); #1 req_valid = 4'b1011;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("bp_resp_valid", 64'(resp_valid), 1);
         check("bp_resp_id", 64'(resp_id), 2);
         check("bp_resp_error", 64'(resp_error), 0);
         check("bp_resp_state", 64'(resp_state === exp_st), 1);
         check("bp_req_ready", 64'(req_ready), 0);
         check("bp_core_reset", 64'(core_reset), 1);
      end
      @(posedge clk); #1 req_valid = '0; resp_ready = 1'b1;
      wait_sb_empty("bp_drain", 10);
      check("bp_jobs_done", 64'(jobs_done), 9);

      // Watchdog abort: core never finishes.
      core_hang = 1'b1;
      run_job("timeout", 4'b0010, 1, 1'b1, acc, rsp);
      check("timeout_latency", 64'(rsp - (acc + 1)), 64);
      check("timeout_jobs_done", 64'(jobs_done), 9);
      core_hang = 1'b0;

      // Counter wrap from 0xFFFF.
      @(negedge clk);
      force dut.jobs_done_q = 16'hFFFF;
      #1 release dut.jobs_done_q;
      @(negedge clk);
      check("wrap_preload", 64'(jobs_done), 64'hFFFF);
      run_job("wrap", 4'b0001, 0, 1'b0, acc, rsp);
      @(negedge clk);
      check("wrap_jobs_done", 64'(jobs_done), 0);

      // Reset during RUN cycle 3: job discarded, arbiter pointer back to N_REQ-1.
      @(posedge clk); #1 req_valid = 4'b0010;
      wait_accept("rst_run", 40, acc);
      check("rst_run_grant", 64'(req_ready), 64'b0010);
      @(posedge clk); #1 req_valid = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst_run_core_reset_now", 64'(core_reset), 1);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("rst_run_busy", 64'(busy), 0);
      check("rst_run_resp_valid", 64'(resp_valid), 0);
      check("rst_run_core_reset", 64'(core_reset), 1);
      check("rst_run_core_in_valid", 64'(core_in_valid), 0);
      run_job("post_rst_all", 4'hF, 0, 1'b0, acc, rsp);
      run_job("post_rst_id3", 4'b1000, 3, 1'b0, acc, rsp);
      repeat (5) @(negedge clk);
      check("final_sb_empty", 64'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got simulation still running, required completion");
      $fatal(1, "time limit");
   end

endmodule
